ks_multiword_adder: RTL and testbench

//   Multi-precision adder built on the 16-bit kogge_stone_adder. Accepts WIDTH-bit

---
 rtl/ks_multiword_adder.sv | 144 ++++++++++++++
 tb/tb_ks_multiword_adder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ks_multiword_adder.sv
`default_nettype none
// ============================================================================
// Module  : ks_multiword_adder (+ kogge_stone_adder)
// Brief   : WIDTH-bit adder that sequences one 16-bit Kogge-Stone adder over
//           the operand chunks, LSB first, with valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================

module kogge_stone_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g_lvl [0:4];
    logic [15:0] p_lvl [0:3];

    // Carry-in is folded into bit 0's generate so every prefix includes it.
    assign p_lvl[0] = a ^ b;
    assign g_lvl[0] = {a[15:1] & b[15:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};

    generate
        for (genvar l = 0; l < 4; l++) begin : g_level
            localparam int D = 1 << l;
            assign g_lvl[l+1] = g_lvl[l] | (p_lvl[l] & (g_lvl[l] << D));
            if (l < 3) begin : g_prop
                assign p_lvl[l+1] = p_lvl[l] & ((p_lvl[l] << D) | 16'((1 << D) - 1));
            end
        end
    endgenerate

    assign sum  = p_lvl[0] ^ {g_lvl[4][14:0], cin};
    assign cout = g_lvl[4][15];
endmodule

module ks_multiword_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);
    localparam int NCHUNK = WIDTH / 16;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [15:0]      chunk_a;
    logic [15:0]      chunk_b;
    logic [15:0]      chunk_sum;
    logic             chunk_cout;
    logic             last_chunk;

    assign chunk_a    = a_q[idx*16 +: 16];
    assign chunk_b    = b_q[idx*16 +: 16];
    assign last_chunk = (idx == LAST_IDX);

    kogge_stone_adder u_ks (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_valid)   next_state = ST_ADD;
            ST_ADD:  if (last_chunk) next_state = ST_DONE;
            ST_DONE: if (out_ready)  next_state = ST_IDLE;
            default:                 next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            S       <= '0;
            Cout    <= 1'b0;
            V       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Cin;
                        idx     <= '0;
                    end
                end
                ST_ADD: begin
                    S[idx*16 +: 16] <= chunk_sum;
                    carry_q         <= chunk_cout;
                    idx             <= idx + 1'b1;
                    // Top chunk's sum bit 15 is the sign of the full result.
                    if (last_chunk) begin
                        Cout <= chunk_cout;
                        V    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                (chunk_sum[15] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ks_multiword_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ks_multiword_adder
// Brief   : Scoreboard bench for ks_multiword_adder at WIDTH=64.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ks_multiword_adder;
    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] S;
    logic         Cout;
    logic         V;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ks_multiword_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .V         (V)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t        r;
        logic [W:0]  t;
        t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.s = t[W-1:0];
        r.c = t[W];
        r.v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input bit push);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Scramble inputs so any late sampling of A/B shows up as a wrong sum.
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        Cin = 1'b0;
        if (push) q.push_back(model(a, b, cin));
    endtask

    task automatic finish_op(input string tag, input int hold);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd4);
        if (q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = q.pop_front();
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check({tag, "_hold_S"}, S, e.s);
            check({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
            check({tag, "_hold_out_valid"}, {63'd0, out_valid}, 64'd1);
        end
        check({tag, "_S"}, S, e.s);
        check({tag, "_Cout"}, {63'd0, Cout}, {63'd0, e.c});
        check({tag, "_V"}, {63'd0, V}, {63'd0, e.v});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_consumed"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_S", S, 64'd0);
        check("rst_CV", {62'd0, Cout, V}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        start_op(64'd0, 64'd0, 1'b1, 1'b1);                           finish_op("t1", 0);
        start_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b1);        finish_op("t2", 0);
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);        finish_op("t3", 0);
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);        finish_op("t4a", 0);
        start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        finish_op("t4b", 0);
        for (int i = 0; i < 4; i++) begin
            start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1);
            finish_op("rnd", 0);
        end

        // Backpressure with an in_valid pulse that must be ignored.
        start_op(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b1, 1'b1);
        finish_op("t5", 5);
        tick();
        check("t5_idle_after", {63'd0, in_ready}, 64'd1);

        // Reset after two chunks have been written.
        start_op(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
        tick();
        tick();
        check("t6_partial", {32'd0, S[31:0]}, 64'h0000_0000_3333_3333);
        rst_n = 1'b0;
        #1;
        check("t6_rst_S", S, 64'd0);
        check("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_idle", {63'd0, in_ready}, 64'd1);
        start_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b1);
        finish_op("t6", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
